fft_r2_datapath_prims: RTL and testbench

// - Datapath primitive set for the 256-point in-place radix-2 DIT FFT engine; the FFT top-level FSM instantiates these primitives.
// - Bundles three independent functions:
//   - a 256x64 dual-port working RAM;
//   - an input/output address counter with bit-reversed copy;
//   - a combinational twiddle-multiply butterfly.
// - Complex word format: [63:32] real, [31:0] imag, each signed Q16.16.

---
 rtl/fft_r2_datapath_prims_pkg.sv | 38 +++
 rtl/fft_r2_datapath_prims_bfly.sv | 50 +++++
 rtl/fft_r2_datapath_prims_gen_addr.sv | 27 ++
 rtl/fft_r2_datapath_prims_ram.sv | 32 +++
 rtl/fft_r2_datapath_prims.sv | 54 +++++
 tb/tb_fft_r2_datapath_prims.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/fft_r2_datapath_prims_pkg.sv
// fft_r2_datapath_prims_pkg: shared constants and helpers for the radix-2 FFT datapath primitives
// Contents: AW/DW/N/TW_FRAC, re/im field slices, bit reversal, Q1.14 twiddle constant builder.
package fft_r2_datapath_prims_pkg;
    localparam int AW      = 8;
    localparam int DW      = 64;
    localparam int N       = 1 << AW;
    localparam int TW_FRAC = 14;

    function automatic logic signed [31:0] re_of(input logic [DW-1:0] x);
        return x[63:32];
    endfunction

    function automatic logic signed [31:0] im_of(input logic [DW-1:0] x);
        return x[31:0];
    endfunction

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    // Round half away from zero; exact ties never occur for these angles.
    function automatic int round_q(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Returns {C, S} for W = exp(-j*2*pi*k/N), both signed Q1.14.
    function automatic logic [31:0] tw_cs(input int k);
        real ang;
        logic signed [15:0] c16;
        logic signed [15:0] s16;
        ang = 2.0 * 3.14159265358979323846 * k / N;
        c16 = 16'(round_q(16384.0 * $cos(ang)));
        s16 = 16'(round_q(16384.0 * $sin(ang)));
        return {c16, s16};
    endfunction
endpackage

// File: rtl/fft_r2_datapath_prims_bfly.sv
// butterfly_operation: combinational radix-2 DIT butterfly with internal twiddle ROM
// Ports: w_i twiddle index k, a_i/b_i complex inputs {re,im} Q16.16,
//        qa_o = A + W*B, qb_o = A - W*B with W = exp(-j*2*pi*k/N), wrapping arithmetic.
module butterfly_operation
    import fft_r2_datapath_prims_pkg::*;
(
    input  logic [AW-1:0] w_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] qa_o,
    output logic [DW-1:0] qb_o
);
    logic [31:0]        rom [N];
    logic [31:0]        cs;
    logic signed [15:0] c;
    logic signed [15:0] s;
    logic signed [31:0] br;
    logic signed [31:0] bi;
    logic signed [63:0] c_x;
    logic signed [63:0] s_x;
    logic signed [63:0] br_x;
    logic signed [63:0] bi_x;
    logic signed [63:0] p_re;
    logic signed [63:0] p_im;
    logic [31:0]        t_re;
    logic [31:0]        t_im;

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = tw_cs(g);
    end

    assign cs   = rom[w_i];
    assign c    = cs[31:16];
    assign s    = cs[15:0];
    assign br   = re_of(b_i);
    assign bi   = im_of(b_i);
    assign c_x  = {{48{c[15]}}, c};
    assign s_x  = {{48{s[15]}}, s};
    assign br_x = {{32{br[31]}}, br};
    assign bi_x = {{32{bi[31]}}, bi};

    // Full-width products, arithmetic shift, then wrap to 32 bits.
    assign p_re = br_x * c_x + bi_x * s_x;
    assign p_im = bi_x * c_x - br_x * s_x;
    assign t_re = 32'(p_re >>> TW_FRAC);
    assign t_im = 32'(p_im >>> TW_FRAC);

    assign qa_o = {a_i[63:32] + t_re, a_i[31:0] + t_im};
    assign qb_o = {a_i[63:32] - t_re, a_i[31:0] - t_im};
endmodule

// File: rtl/fft_r2_datapath_prims_gen_addr.sv
// gen_addr: natural-order address counter with bit-reversed copy and end-of-sweep flag
// Ports: clk, rst_n (async active-low), en_i advance enable,
//        done_o = en_i at address N-1, addr_o natural address, re_o bit-reversed address.
module gen_addr
    import fft_r2_datapath_prims_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    output logic          done_o,
    output logic [AW-1:0] addr_o,
    output logic [AW-1:0] re_o
);
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    assign addr_d = en_i ? addr_q + 1'b1 : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_q <= '0;
        else        addr_q <= addr_d;
    end

    assign addr_o = addr_q;
    assign re_o   = bitrev(addr_q);
    assign done_o = en_i & (&addr_q);
endmodule

// File: rtl/fft_r2_datapath_prims_ram.sv
// dual_port_ram: N x DW read-first dual-port RAM with a shared write strobe
// Ports: clk, wr_n_i (0 = write both ports), da_i/db_i write data, aa_i/ab_i addresses,
//        qa_o/qb_o registered read data (pre-write contents). No reset.
module dual_port_ram
    import fft_r2_datapath_prims_pkg::*;
(
    input  logic          clk,
    input  logic          wr_n_i,
    input  logic [DW-1:0] da_i,
    input  logic [DW-1:0] db_i,
    input  logic [AW-1:0] aa_i,
    input  logic [AW-1:0] ab_i,
    output logic [DW-1:0] qa_o,
    output logic [DW-1:0] qb_o
);
    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] qa_q;
    logic [DW-1:0] qb_q;

    // Port B write is issued last so it wins when both ports hit the same word.
    always_ff @(posedge clk) begin
        qa_q <= mem_q[aa_i];
        qb_q <= mem_q[ab_i];
        if (!wr_n_i) begin
            mem_q[aa_i] <= da_i;
            mem_q[ab_i] <= db_i;
        end
    end

    assign qa_o = qa_q;
    assign qb_o = qb_q;
endmodule

// File: rtl/fft_r2_datapath_prims.sv
// fft_r2_datapath_prims: bundle of address counter, dual-port working RAM and butterfly
// Ports: clk, rst (async active-low, counter only); ag_en/ag_done/ag_addr/ag_re counter;
//        ram_wr (0 = write)/ram_da/ram_db/ram_aa/ram_ab/ram_qa/ram_qb RAM;
//        bf_w/bf_a/bf_b/bf_qa/bf_qb butterfly.
module fft_r2_datapath_prims
    import fft_r2_datapath_prims_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ag_en,
    output logic          ag_done,
    output logic [AW-1:0] ag_addr,
    output logic [AW-1:0] ag_re,
    input  logic          ram_wr,
    input  logic [DW-1:0] ram_da,
    input  logic [DW-1:0] ram_db,
    input  logic [AW-1:0] ram_aa,
    input  logic [AW-1:0] ram_ab,
    output logic [DW-1:0] ram_qa,
    output logic [DW-1:0] ram_qb,
    input  logic [AW-1:0] bf_w,
    input  logic [DW-1:0] bf_a,
    input  logic [DW-1:0] bf_b,
    output logic [DW-1:0] bf_qa,
    output logic [DW-1:0] bf_qb
);
    gen_addr u_gen_addr (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (ag_en),
        .done_o (ag_done),
        .addr_o (ag_addr),
        .re_o   (ag_re)
    );

    dual_port_ram u_ram (
        .clk    (clk),
        .wr_n_i (ram_wr),
        .da_i   (ram_da),
        .db_i   (ram_db),
        .aa_i   (ram_aa),
        .ab_i   (ram_ab),
        .qa_o   (ram_qa),
        .qb_o   (ram_qb)
    );

    butterfly_operation u_bfly (
        .w_i  (bf_w),
        .a_i  (bf_a),
        .b_i  (bf_b),
        .qa_o (bf_qa),
        .qb_o (bf_qb)
    );
endmodule

// File: tb/tb_fft_r2_datapath_prims.sv
// tb_fft_r2_datapath_prims: self-checking bench for counter, RAM and butterfly primitives
module tb_fft_r2_datapath_prims;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ag_en = 1'b1;
    logic        ag_done;
    logic [7:0]  ag_addr;
    logic [7:0]  ag_re;
    logic        ram_wr = 1'b1;
    logic [63:0] ram_da = '0;
    logic [63:0] ram_db = '0;
    logic [7:0]  ram_aa = '0;
    logic [7:0]  ram_ab = '0;
    logic [63:0] ram_qa;
    logic [63:0] ram_qb;
    logic [7:0]  bf_w = '0;
    logic [63:0] bf_a = '0;
    logic [63:0] bf_b = '0;
    logic [63:0] bf_qa;
    logic [63:0] bf_qb;

    fft_r2_datapath_prims dut (
        .clk(clk), .rst(rst),
        .ag_en(ag_en), .ag_done(ag_done), .ag_addr(ag_addr), .ag_re(ag_re),
        .ram_wr(ram_wr), .ram_da(ram_da), .ram_db(ram_db), .ram_aa(ram_aa), .ram_ab(ram_ab),
        .ram_qa(ram_qa), .ram_qb(ram_qb),
        .bf_w(bf_w), .bf_a(bf_a), .bf_b(bf_b), .bf_qa(bf_qa), .bf_qb(bf_qb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int brev(input int a);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((a >> i) & 1);
        return r;
    endfunction

    function automatic longint rnd(input real x);
        return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
    endfunction

    // Returns {qa, qb} from the complex formula with integer twiddles.
    function automatic logic [127:0] bf_model(input int k, input logic [63:0] a, input logic [63:0] b);
        real th = 2.0 * 3.141592653589793 * k / 256.0;
        longint c  = rnd(16384.0 * $cos(th));
        longint s  = rnd(16384.0 * $sin(th));
        longint ar = longint'(int'(a[63:32]));
        longint ai = longint'(int'(a[31:0]));
        longint br = longint'(int'(b[63:32]));
        longint bi = longint'(int'(b[31:0]));
        longint tr = (br * c + bi * s) >>> 14;
        longint ti = (bi * c - br * s) >>> 14;
        logic [31:0] qar = 32'(ar + tr);
        logic [31:0] qai = 32'(ai + ti);
        logic [31:0] qbr = 32'(ar - tr);
        logic [31:0] qbi = 32'(ai - ti);
        return {qar, qai, qbr, qbi};
    endfunction

    logic [63:0] mdl [256];
    bit          vld [256];

    task automatic ram_op(input logic wr, input logic [7:0] aa, input logic [7:0] ab,
                          input logic [63:0] da, input logic [63:0] db);
        logic [63:0] ea = mdl[aa];
        logic [63:0] eb = mdl[ab];
        bit va = vld[aa];
        bit vb = vld[ab];
        ram_wr = wr; ram_aa = aa; ram_ab = ab; ram_da = da; ram_db = db;
        tick();
        if (va) check("ram_qa", ram_qa, ea);
        if (vb) check("ram_qb", ram_qb, eb);
        if (!wr) begin
            mdl[aa] = da; vld[aa] = 1'b1;
            mdl[ab] = db; vld[ab] = 1'b1;
        end
        ram_wr = 1'b1;
    endtask

    typedef struct {
        string       name;
        int          k;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] qa;
        logic [63:0] qb;
    } bvec_t;

    bvec_t tbl [6];

    initial begin
        int exp_addr;
        logic [127:0] m;
        tbl[0] = '{"bf_k0",     0,   64'h0001_0000_0000_0000, 64'h0000_8000_0000_0000, 64'h0001_8000_0000_0000, 64'h0000_8000_0000_0000};
        tbl[1] = '{"bf_k64",    64,  64'h0000_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000};
        tbl[2] = '{"bf_k128",   128, 64'h0000_0000_0000_0000, 64'h0001_0000_0002_0000, 64'hFFFF_0000_FFFE_0000, 64'h0001_0000_0002_0000};
        tbl[3] = '{"bf_k192",   192, 64'h0000_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_FFFF_0000};
        tbl[4] = '{"bf_wrap",   0,   64'h7FFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFE_0000_0000};
        tbl[5] = '{"bf_floor",  32,  64'h0000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001};

        // Counter held in reset while the clock runs.
        #22;
        check("rst_addr", 64'(ag_addr), 64'd0);
        check("rst_re",   64'(ag_re),   64'd0);
        check("rst_done", 64'(ag_done), 64'd0);

        // Butterfly: fixed vectors then random against the model.
        foreach (tbl[i]) begin
            bf_w = 8'(tbl[i].k); bf_a = tbl[i].a; bf_b = tbl[i].b;
            #1;
            check({tbl[i].name, "_qa"}, bf_qa, tbl[i].qa);
            check({tbl[i].name, "_qb"}, bf_qb, tbl[i].qb);
        end
        for (int i = 0; i < 60; i++) begin
            bf_w = 8'($urandom_range(0, 255));
            bf_a = {$urandom, $urandom};
            bf_b = (i < 20) ? {16'($urandom_range(0, 3) * 16'h5555), 16'($urandom), 16'($urandom), 16'($urandom)} : {$urandom, $urandom};
            #1;
            m = bf_model(int'(bf_w), bf_a, bf_b);
            check("bf_rand_qa", bf_qa, m[127:64]);
            check("bf_rand_qb", bf_qb, m[63:0]);
        end

        // Full sweep plus wrap and part of a second sweep up to 37.
        @(posedge clk); #1;
        rst = 1'b1;
        exp_addr = 0;
        for (int n = 0; n < 256 + 37; n++) begin
            check("sweep_addr", 64'(ag_addr), 64'(exp_addr));
            check("sweep_re",   64'(ag_re),   64'(brev(exp_addr)));
            check("sweep_done", 64'(ag_done), 64'(exp_addr == 255));
            if (exp_addr == 1) check("re_of_1", 64'(ag_re), 64'd128);
            if (exp_addr == 6) check("re_of_6", 64'(ag_re), 64'd96);
            tick();
            exp_addr = (exp_addr + 1) % 256;
        end
        check("addr_37", 64'(ag_addr), 64'd37);

        ag_en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("hold_addr", 64'(ag_addr), 64'd37);
            check("hold_done", 64'(ag_done), 64'd0);
        end
        ag_en = 1'b1;
        for (int n = 0; n < 53; n++) tick();
        check("addr_90", 64'(ag_addr), 64'd90);
        #2 rst = 1'b0;
        #1;
        check("async_rst_addr", 64'(ag_addr), 64'd0);
        ag_en = 1'b0;
        #2 rst = 1'b1;
        tick();
        check("post_rst_hold", 64'(ag_addr), 64'd0);
        ag_en = 1'b1;
        tick();
        check("post_rst_inc", 64'(ag_addr), 64'd1);
        ag_en = 1'b0;

        // RAM directed sequences.
        ram_op(1'b0, 8'd5, 8'd10, 64'h0001_0000_0000_0000, 64'h1234);
        ram_op(1'b1, 8'd5, 8'd10, 64'h0, 64'h0);
        check("ram_rd_a5",  ram_qa, 64'h0001_0000_0000_0000);
        check("ram_rd_b10", ram_qb, 64'h1234);
        ram_op(1'b0, 8'd7, 8'd7, 64'hA7A7, 64'hB7B7);
        ram_op(1'b1, 8'd7, 8'd7, 64'h0, 64'h0);
        check("ram_same_addr_b_wins", ram_qa, 64'hB7B7);
        ram_op(1'b0, 8'd3, 8'd200, 64'hAA, 64'h0);
        ram_op(1'b0, 8'd3, 8'd201, 64'hBB, 64'h0);
        check("ram_read_first", ram_qa, 64'hAA);
        ram_op(1'b1, 8'd3, 8'd3, 64'h0, 64'h0);
        check("ram_after_rw", ram_qa, 64'hBB);

        // RAM random traffic on a small address window to force collisions.
        for (int i = 0; i < 200; i++)
            ram_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                   {$urandom, $urandom}, {$urandom, $urandom});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
